rst_req_gen: RTL and testbench

Reset-request initiator that drives the active-high reset-request input of the core reset controller. Two sources can raise a request: a watchdog timeout, and a software reset request. Each request becomes a fixed-length, glitch-free request pulse. The block sits in the always-on reset domain (external reset only), so the recorded reset cause survives the core reset it triggers.

---
 rtl/rst_req_gen_pkg.sv | 16 +
 rtl/rst_req_pulse.sv | 50 +++++
 rtl/rst_req_gen.sv | 108 ++++++++++
 tb/tb_rst_req_gen.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_req_gen_pkg.sv
// Shared encodings and defaults for the reset-request initiator and its helpers.
package rst_req_gen_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_REARM = 2'd3;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_WDT  = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;

  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_WARN_CYCLES = 256;

endpackage

// File: rtl/rst_req_pulse.sv
// Fixed-length, glitch-free pulse stretcher; done_o marks the last high cycle.
module rst_req_pulse
  import rst_req_gen_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic pulse_o,
  output logic done_o
);

  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign done_o  = pulse_q && (cnt_q == LAST);
  assign pulse_o = pulse_q;

  // A start while already pulsing is ignored so a pulse is never extended.
  always_comb begin
    pulse_d = pulse_q;
    cnt_d   = cnt_q;
    if (pulse_q) begin
      if (done_o) begin
        pulse_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (start_i) begin
      pulse_d = 1'b1;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/rst_req_gen.sv
// Reset-request initiator: watchdog timeout or software request -> fixed-length rst_req_o.
module rst_req_gen
  import rst_req_gen_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int WARN_CYCLES = DEF_WARN_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             kick_i,
  input  logic [CNT_W-1:0] timeout_i,
  input  logic             sw_rst_req_i,
  input  logic             cause_clr_i,
  output logic             rst_req_o,
  output logic             warn_irq_o,
  output logic [1:0]       cause_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] WARN_TH = CNT_W'(WARN_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             warn_q, warn_d;
  logic [1:0]       cause_q, cause_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] reload;
  logic [1:0]       new_cause;
  logic             kick_clr;
  logic             hold_start;
  logic             hold_done;

  assign reload     = (timeout_i == '0) ? ONE : timeout_i;
  assign hold_start = (new_cause != CAUSE_NONE);

  // Priority inside COUNT: software > disable > kick > expiry > decrement.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    new_cause = CAUSE_NONE;
    kick_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sw_rst_req_i) new_cause = CAUSE_SW;
        else if (en_i) begin
          state_d = ST_COUNT;
          cnt_d   = reload;
        end
      end
      ST_COUNT: begin
        if (sw_rst_req_i)  new_cause = CAUSE_SW;
        else if (!en_i)    state_d = ST_IDLE;
        else if (kick_i) begin
          cnt_d    = reload;
          kick_clr = 1'b1;
        end
        else if (cnt_q <= ONE) new_cause = CAUSE_WDT;
        else               cnt_d = cnt_q - ONE;
      end
      ST_HOLD: begin
        if (hold_done) state_d = ST_REARM;
      end
      default: begin
        if (sw_rst_req_i) new_cause = CAUSE_SW;
        else if (!en_i)   state_d = ST_IDLE;
      end
    endcase
    if (new_cause != CAUSE_NONE) state_d = ST_HOLD;

    cause_d = cause_clr_i ? CAUSE_NONE : cause_q;
    if (new_cause != CAUSE_NONE) cause_d = new_cause;

    warn_d = (state_d == ST_COUNT) && !kick_clr && (cnt_d <= WARN_TH);
    busy_d = (state_d == ST_HOLD) || (state_d == ST_REARM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      warn_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      warn_q  <= warn_d;
      cause_q <= cause_d;
      busy_q  <= busy_d;
    end
  end

  rst_req_pulse #(.HOLD_CYCLES(HOLD_CYCLES)) u_pulse (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (hold_start),
    .pulse_o (rst_req_o),
    .done_o  (hold_done)
  );

  assign warn_irq_o = warn_q;
  assign cause_o    = cause_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_rst_req_gen.sv
// Bench for rst_req_gen: directed scenarios plus a randomized run against a behavioural model.
module tb_rst_req_gen;

  localparam int CNT_W = 32;
  localparam int WARN  = 10;
  localparam int HOLD  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en_i = 1'b0;
  logic             kick_i = 1'b0;
  logic [CNT_W-1:0] timeout_i = '0;
  logic             sw_rst_req_i = 1'b0;
  logic             cause_clr_i = 1'b0;
  logic             rst_req_o, warn_irq_o, busy_o;
  logic [1:0]       cause_o;

  int checks = 0;
  int errors = 0;

  rst_req_gen #(.CNT_W(CNT_W), .WARN_CYCLES(WARN), .HOLD_CYCLES(HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .kick_i       (kick_i),
    .timeout_i    (timeout_i),
    .sw_rst_req_i (sw_rst_req_i),
    .cause_clr_i  (cause_clr_i),
    .rst_req_o    (rst_req_o),
    .warn_irq_o   (warn_irq_o),
    .cause_o      (cause_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    en_i = 0; kick_i = 0; sw_rst_req_i = 0; cause_clr_i = 0;
    repeat (20) step();
  endtask

  // Observed vector order: {rst_req, warn, busy, cause[1:0]}
  task automatic test_reset();
    logic [4:0] exp;
    rst_n = 1; #2; rst_n = 0; #10;
    exp = 5'b0;
    if ({rst_req_o, warn_irq_o, busy_o, cause_o} !== exp) begin
      errors++;
      $display("FAIL reset got %b want %b", {rst_req_o, warn_irq_o, busy_o, cause_o}, exp);
    end
    checks++;
    @(negedge clk) rst_n = 1;
    step();
  endtask

  task automatic test_expiry();
    logic [4:0] exp;
    timeout_i = 100; en_i = 1;
    for (int k = 0; k < 120; k++) begin
      step();
      exp = {(k >= 100 && k < 100 + HOLD), (k >= 90 && k < 100), (k >= 100),
             (k >= 100) ? 2'b01 : 2'b00};
      if ({rst_req_o, warn_irq_o, busy_o, cause_o} !== exp) begin
        errors++;
        $display("FAIL expiry k=%0d got %b want %b", k, {rst_req_o, warn_irq_o, busy_o, cause_o}, exp);
      end
      checks++;
    end
  endtask

  task automatic test_rearm();
    logic [4:0] exp;
    for (int k = 0; k < 200; k++) begin
      step();
      exp = 5'b00101;
      if ({rst_req_o, warn_irq_o, busy_o, cause_o} !== exp) begin
        errors++;
        $display("FAIL rearm_hold k=%0d got %b want %b", k, {rst_req_o, warn_irq_o, busy_o, cause_o}, exp);
      end
      checks++;
    end
    en_i = 0; timeout_i = 20;
    step();
    exp = 5'b00001;
    if ({rst_req_o, warn_irq_o, busy_o, cause_o} !== exp) begin
      errors++;
      $display("FAIL rearm_release got %b want %b", {rst_req_o, warn_irq_o, busy_o, cause_o}, exp);
    end
    checks++;
    en_i = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      exp = {(k >= 20 && k < 20 + HOLD), (k >= 10 && k < 20), (k >= 20), 2'b01};
      if ({rst_req_o, warn_irq_o, busy_o, cause_o} !== exp) begin
        errors++;
        $display("FAIL rearm_restart k=%0d got %b want %b", k, {rst_req_o, warn_irq_o, busy_o, cause_o}, exp);
      end
      checks++;
    end
    go_idle();
  endtask

  task automatic test_kick();
    logic [4:0] exp;
    timeout_i = 50; en_i = 1;
    for (int k = 0; k < 500; k++) begin
      kick_i = (k % 40 == 39);
      step();
      exp = 5'b00001;
      if ({rst_req_o, warn_irq_o, busy_o, cause_o} !== exp) begin
        errors++;
        $display("FAIL kick_periodic k=%0d got %b want %b", k, {rst_req_o, warn_irq_o, busy_o, cause_o}, exp);
      end
      checks++;
    end
    kick_i = 0; en_i = 0;
    step();
    en_i = 1;
    for (int k = 0; k < 90; k++) begin
      kick_i = (k == 50);
      step();
      exp = {1'b0, (k >= 40 && k < 50), 1'b0, 2'b01};
      if ({rst_req_o, warn_irq_o, busy_o, cause_o} !== exp) begin
        errors++;
        $display("FAIL kick_at_expiry k=%0d got %b want %b", k, {rst_req_o, warn_irq_o, busy_o, cause_o}, exp);
      end
      checks++;
    end
    go_idle();
  endtask

  task automatic test_sw();
    logic [4:0] exp;
    timeout_i = 30; en_i = 1;
    for (int k = 0; k < 60; k++) begin
      sw_rst_req_i = (k == 30 || k == 35);
      step();
      exp = {(k >= 30 && k < 30 + HOLD), (k >= 20 && k < 30), (k >= 30),
             (k >= 30) ? 2'b10 : 2'b01};
      if ({rst_req_o, warn_irq_o, busy_o, cause_o} !== exp) begin
        errors++;
        $display("FAIL sw_vs_expiry k=%0d got %b want %b", k, {rst_req_o, warn_irq_o, busy_o, cause_o}, exp);
      end
      checks++;
    end
    go_idle();
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] exp;
    timeout_i = 5; en_i = 1;
    for (int k = 0; k < 10; k++) step();
    if (rst_req_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_hold_pre got %b want 1", rst_req_o);
    end
    checks++;
    #2 rst_n = 0;
    #1;
    exp = 5'b0;
    if ({rst_req_o, warn_irq_o, busy_o, cause_o} !== exp) begin
      errors++;
      $display("FAIL mid_hold_async got %b want %b", {rst_req_o, warn_irq_o, busy_o, cause_o}, exp);
    end
    checks++;
    @(negedge clk);
    en_i = 0; rst_n = 1;
    step();
    if ({rst_req_o, warn_irq_o, busy_o, cause_o} !== exp) begin
      errors++;
      $display("FAIL mid_hold_release got %b want %b", {rst_req_o, warn_irq_o, busy_o, cause_o}, exp);
    end
    checks++;
    timeout_i = 3; en_i = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      exp = {(k >= 3), (k < 3), (k >= 3), (k >= 3) ? 2'b01 : 2'b00};
      if ({rst_req_o, warn_irq_o, busy_o, cause_o} !== exp) begin
        errors++;
        $display("FAIL mid_hold_idle k=%0d got %b want %b", k, {rst_req_o, warn_irq_o, busy_o, cause_o}, exp);
      end
      checks++;
    end
    go_idle();
  endtask

  task automatic test_edges();
    logic [4:0] exp;
    sw_rst_req_i = 1; cause_clr_i = 1;
    step();
    sw_rst_req_i = 0; cause_clr_i = 0;
    exp = 5'b10110;
    if ({rst_req_o, warn_irq_o, busy_o, cause_o} !== exp) begin
      errors++;
      $display("FAIL clr_vs_sw got %b want %b", {rst_req_o, warn_irq_o, busy_o, cause_o}, exp);
    end
    checks++;
    go_idle();
    timeout_i = 0; en_i = 1;
    step();
    exp = 5'b01010;
    if ({rst_req_o, warn_irq_o, busy_o, cause_o} !== exp) begin
      errors++;
      $display("FAIL timeout0_load got %b want %b", {rst_req_o, warn_irq_o, busy_o, cause_o}, exp);
    end
    checks++;
    cause_clr_i = 1;
    step();
    cause_clr_i = 0;
    exp = 5'b10101;
    if ({rst_req_o, warn_irq_o, busy_o, cause_o} !== exp) begin
      errors++;
      $display("FAIL timeout0_expiry got %b want %b", {rst_req_o, warn_irq_o, busy_o, cause_o}, exp);
    end
    checks++;
    go_idle();
    cause_clr_i = 1;
    step();
    cause_clr_i = 0;
    if (cause_o !== 2'b00) begin
      errors++;
      $display("FAIL cause_clear got %b want 00", cause_o);
    end
    checks++;
  endtask

  // Model: remaining count, pulse cycles left, and a "waiting for enable low" flag.
  task automatic test_random();
    int         m_rem, m_hold, to;
    bit         m_on, m_wait, m_warn, kicked;
    logic [1:0] m_cause, nc;
    logic [4:0] exp;
    rst_n = 0; en_i = 0; kick_i = 0; sw_rst_req_i = 0; cause_clr_i = 0;
    #3;
    @(negedge clk) rst_n = 1;
    step();
    m_rem = 0; m_hold = 0; m_on = 0; m_wait = 0; m_warn = 0; m_cause = 2'b00;
    en_i = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 4) en_i = ~en_i;
      kick_i       = ($urandom_range(0, 99) < 4);
      sw_rst_req_i = ($urandom_range(0, 99) < 2);
      cause_clr_i  = ($urandom_range(0, 99) < 3);
      to           = int'($urandom_range(0, 40));
      timeout_i    = CNT_W'(to);
      kicked = 0; nc = 2'b00;
      if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_wait = 1;
      end
      else if (sw_rst_req_i) nc = 2'b10;
      else if (m_wait) begin
        if (!en_i) m_wait = 0;
      end
      else if (!m_on) begin
        if (en_i) begin m_on = 1; m_rem = (to == 0) ? 1 : to; end
      end
      else if (!en_i) m_on = 0;
      else if (kick_i) begin m_rem = (to == 0) ? 1 : to; kicked = 1; end
      else if (m_rem == 1) nc = 2'b01;
      else m_rem--;
      if (nc != 2'b00) begin m_hold = HOLD; m_on = 0; m_wait = 0; end
      if (cause_clr_i) m_cause = 2'b00;
      if (nc != 2'b00) m_cause = nc;
      m_warn = m_on && !kicked && (m_rem <= WARN);
      step();
      exp = {(m_hold > 0), m_warn, (m_hold > 0) || m_wait, m_cause};
      if ({rst_req_o, warn_irq_o, busy_o, cause_o} !== exp) begin
        errors++;
        $display("FAIL random c=%0d got %b want %b", c, {rst_req_o, warn_irq_o, busy_o, cause_o}, exp);
      end
      checks++;
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_expiry();
    test_rearm();
    test_kick();
    test_sw();
    test_reset_mid_hold();
    test_edges();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
